// File: rtl/serial_add.sv
// Multi-cycle adder that adds DIGIT bits per clock, with the carry held in a flip-flop between digits.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) ||
        (((DIGIT < 1) ? 0 : (WIDTH % DIGIT)) != 0)) begin : g_bad_params
      $error("serial_add: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_s;
  logic               r_co;

  logic               w_accept;
  logic               w_last;
  logic [DIGIT:0]     w_digit_full;
  logic [DIGIT-1:0]   w_digit_sum;
  logic               w_digit_carry;
  logic [WIDTH-1:0]   w_sum_next;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_count == CNT_W'(N - 1));

  // One digit of the add; the extra top bit is the digit carry-out.
  assign w_digit_full  = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, r_carry};
  assign w_digit_sum   = w_digit_full[DIGIT-1:0];
  assign w_digit_carry = w_digit_full[DIGIT];

  // Digit sums enter at the top, so after N shifts digit 0 sits at the LSB.
  assign w_sum_next = (r_sum >> DIGIT) | (WIDTH'(w_digit_sum) << (WIDTH - DIGIT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = start ? S_RUN : S_IDLE;
      S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign s  = r_s;
  assign co = r_co;

  // NOTE: the operand and partial-sum shift registers are reset too, so an
  // aborted add leaves no stale data visible in simulation or on silicon.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_carry <= ci;
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= w_sum_next;
      r_carry <= w_digit_carry;
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Result registers only move on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s  <= '0;
      r_co <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_s  <= w_sum_next;
      r_co <= w_digit_carry;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_ovf <= (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add: DIGIT=1 and DIGIT=4 instances share stimulus
// and are compared each cycle against a countdown/arithmetic reference model.
module tb_serial_add;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       ci;

  logic       d1_busy, d1_done, d1_co;
  logic [7:0] d1_s;
  logic       d4_busy, d4_done, d4_co;
  logic [7:0] d4_s;
`ifdef SERIAL_ADD_OVF_EN
  logic       d1_ovf, d4_ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_add #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
    .busy(d1_busy), .done(d1_done), .s(d1_s), .co(d1_co)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(d1_ovf)
`endif
  );

  serial_add #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
    .busy(d4_busy), .done(d4_done), .s(d4_s), .co(d4_co)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(d4_ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: per instance, cycles left in the add and the pending result.
  int         m_left[2];
  logic       m_done[2];
  logic [8:0] m_sum[2];
  logic       m_ovf[2];
  logic [8:0] p_sum[2];
  logic       p_ovf[2];

  function automatic int n_of(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_left[i] = 0;
        m_done[i] = 1'b0;
        m_sum[i]  = '0;
        m_ovf[i]  = 1'b0;
      end else if (m_left[i] > 0) begin
        m_left[i] = m_left[i] - 1;
        m_done[i] = (m_left[i] == 0);
        if (m_left[i] == 0) begin
          m_sum[i] = p_sum[i];
          m_ovf[i] = p_ovf[i];
        end
      end else begin
        m_done[i] = 1'b0;
        if (start) begin
          m_left[i] = n_of(i);
          p_sum[i]  = 9'(a) + 9'(b) + 9'(ci);
          p_ovf[i]  = (a[7] == b[7]) && (p_sum[i][7] != a[7]);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("d1_busy", d1_busy, m_left[0] > 0);
    check("d1_done", d1_done, m_done[0]);
    check("d1_sum",  {d1_co, d1_s}, m_sum[0]);
    check("d4_busy", d4_busy, m_left[1] > 0);
    check("d4_done", d4_done, m_done[1]);
    check("d4_sum",  {d4_co, d4_s}, m_sum[1]);
`ifdef SERIAL_ADD_OVF_EN
    check("d1_ovf", d1_ovf, m_ovf[0]);
    check("d4_ovf", d4_ovf, m_ovf[1]);
`endif
  end

  task automatic pulse_start(input logic [7:0] ta, input logic [7:0] tb, input logic tci);
    @(negedge clk);
    a = ta; b = tb; ci = tci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_d1_done(input string name);
    for (int i = 0; i < 20; i++) begin
      if (d1_done) return;
      @(negedge clk);
    end
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic add_and_wait(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                              input string name);
    repeat (12) @(negedge clk);
    pulse_start(ta, tb, tci);
    wait_d1_done(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d4_results;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", d1_busy, 1'b0);
    check("rst_done", d1_done, 1'b0);
    check("rst_s",    d1_s,    8'h00);
    check("rst_co",   d1_co,   1'b0);
    rst = 1'b0;

    add_and_wait(8'h5A, 8'h3C, 1'b0, "t2");
    check("t2_s",       d1_s, 8'h96);
    check("t2_co",      d1_co, 1'b0);
    check("t2_model_s", m_sum[0], 9'h096);

    add_and_wait(8'hFF, 8'h00, 1'b1, "t3a");
    check("t3a_s",  d1_s,  8'h00);
    check("t3a_co", d1_co, 1'b1);
    check("t3a_model", m_sum[0], 9'h100);

    add_and_wait(8'h7F, 8'h01, 1'b0, "t3b");
    check("t3b_s",  d1_s,  8'h80);
    check("t3b_co", d1_co, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check("t3b_ovf", d1_ovf, 1'b1);
    check("t3b_model_ovf", m_ovf[0], 1'b1);
`endif

    // start pulsed during RUN with new operands must be ignored
    repeat (12) @(negedge clk);
    pulse_start(8'h12, 8'h34, 1'b1);
    repeat (2) @(negedge clk);
    pulse_start(8'hFF, 8'hFF, 1'b1);
    a = 8'hA5; b = 8'hC3; ci = 1'b0;
    wait_d1_done("t4");
    check("t4_s",  d1_s,  8'h47);
    check("t4_co", d1_co, 1'b0);

    // asynchronous reset mid-cycle at RUN cycle 4
    repeat (12) @(negedge clk);
    pulse_start(8'hC8, 8'h64, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", d1_busy, 1'b0);
    check("t5_done", d1_done, 1'b0);
    check("t5_s",    d1_s,    8'h00);
    check("t5_co",   d1_co,   1'b0);
    check("t5_d4_s", d4_s,    8'h00);
    @(negedge clk);
    rst = 1'b0;
    add_and_wait(8'h03, 8'h04, 1'b0, "t5b");
    check("t5b_s",  d1_s,  8'h07);
    check("t5b_co", d1_co, 1'b0);

    // back-to-back adds with start held high through DONE
    repeat (12) @(negedge clk);
    d4_results = 0;
    start = 1'b1;
    for (int i = 0; i < 3010; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom);
      @(negedge clk);
      if (d4_done) d4_results++;
    end
    check("t6_d4_results", d4_results >= 1000, 1'b1);

    for (int i = 0; i < 500; i++) begin
      start = 1'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
